reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, register-file address width.
REQ-002 Parameter DATA_W, default 16, register data width.
REQ-003 Parameter ADDR_MAX, default 99, highest legal register address.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req0, req1  input  1 each  requester k access request; held high until gntk.
REQ-007 we0, we1  input  1 each  1 = write, 0 = read; stable while reqk high.
REQ-008 addr0, addr1  input  ADDR_W each  target register; stable while reqk high.
REQ-009 wdata0, wdata1  input  DATA_W each  write data; stable while reqk high.
REQ-010 gnt0, gnt1  output  1 each  one-cycle pulse; requester k's command issued/consumed.
REQ-011 err0, err1  output  1 each  one-cycle pulse coincident with gntk when addrk > ADDR_MAX.
REQ-012 rvalid0, rvalid1  output  1 each  one-cycle pulse; rdatak valid.
REQ-013 rdata0, rdata1  output  DATA_W each  read return data, held until next rvalidk.
REQ-014 rf_write, rf_read  output  1 each  register-file write/read strobes.
REQ-015 rf_addr  output  ADDR_W  register-file address.
REQ-016 rf_wdata  output  DATA_W  register-file write data.
REQ-017 rf_rdata  input  DATA_W  register-file read data; valid the cycle after rf_read, zero otherwise.

Function
REQ-018 FSM states IDLE, ISSUE, RDWAIT; all outputs registered.
REQ-019 IDLE: no request -> stay; any request -> latch winner's we/addr/wdata and index, go ISSUE.
REQ-020 Arbitration round-robin: single request wins outright; both high -> requester not granted last wins; pointer initialises to requester 0 after reset.
REQ-021 ISSUE: assert gnt of winner for exactly this cycle; update pointer to the winner.
REQ-022 ISSUE, legal write: rf_write=1, rf_addr/rf_wdata = latched values, next state IDLE.
REQ-023 ISSUE, legal read: rf_read=1, rf_addr = latched address, next state RDWAIT.
REQ-024 ISSUE, addr > ADDR_MAX: no rf strobe, errk=1; read -> rvalidk=1 and rdatak=0 next cycle, write -> nothing further; next state IDLE.
REQ-025 RDWAIT: capture rf_rdata into winner's rdata, pulse its rvalid next cycle, go IDLE.
REQ-026 Latency from reqk rising in IDLE: gntk at cycle +2; read data rvalidk at cycle +4 (one cycle after RDWAIT).
REQ-027 Throughput: write occupies 2 cycles, read 3 cycles; requests arriving outside IDLE wait.
REQ-028 rf_write and rf_read never high together; at most one gnt per cycle.
REQ-029 rf_addr and rf_wdata hold 0 when no strobe active.
REQ-030 rvalid of one requester may coincide with the other's next request latching; no request dropped.
REQ-031 Request withdrawn before gnt (protocol violation) -> command already latched still completes.

Reset
REQ-032 reset_n low asynchronously forces IDLE, pointer to requester 0, all gnt/err/rvalid/rf strobes 0, rf_addr/rf_wdata 0, rdata0/rdata1 0.
REQ-033 Reset mid-operation abandons the in-flight command; no gnt, err or rvalid produced for it after release.
REQ-034 First request is accepted on the first rising edge with reset_n high.

Structure
REQ-035 Shared package holds ADDR_W, DATA_W, ADDR_MAX defaults and FSM state encoding.
REQ-036 One sub-module rr_arb2: two-requester round-robin pick with last-grant pointer input.
REQ-037 Block instantiated alongside the existing 100 x 16 register file; its rf_* ports connect directly to that file's write, read, addr, write_regs and regs_out.

Verification
REQ-038 Write then read: req0 we=1 addr=5 wdata=0xBEEF, then req0 we=0 addr=5 -> gnt0 twice, rvalid0 with rdata0=0xBEEF, 4 cycles after read request.
REQ-039 Contention: req0 and req1 both high reading addr 10/20 after reset -> gnt0 first, gnt1 next; second round both high -> requester 0 first again only if 1 was last granted.
REQ-040 Out of range: req1 we=0 addr=100 -> gnt1 and err1 same cycle, rvalid1 next with rdata1=0, no rf_read.
REQ-041 Out-of-range write addr=127 wdata=0x1234 -> err0 pulse, rf_write never asserted, subsequent read addr=127 -> err, rdata 0.
REQ-042 Reset during RDWAIT -> no rvalid, FSM IDLE, subsequent write/read to addr 99 of 0xA5A5 returns 0xA5A5.
REQ-043 Back-to-back writes from req1 to addresses 0..99 then readback of all 100 -> each rdata equals its write data; rf_write/rf_read never overlap.

Source files
------------

// File: rtl/reg_arbiter_pkg.sv
// Shared defaults and FSM encoding for the two-port register-file arbiter.
package reg_arbiter_pkg;

    localparam int ADDR_W_DEF   = 7;
    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_MAX_DEF = 99;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/reg_arbiter_rr_arb2.sv
// Two-requester round-robin pick. ptr_i names the requester that wins a tie;
// the top keeps it pointing away from whoever was granted last.
module rr_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic ptr_i,
    output logic any_o,
    output logic win_o
);

    // A lone request wins outright; on a tie the pointer decides.
    always_comb begin
        any_o = req0_i | req1_i;
        win_o = 1'b0;
        if (req0_i && req1_i) begin
            win_o = ptr_i;
        end else if (req1_i) begin
            win_o = 1'b1;
        end
    end

endmodule

// File: rtl/reg_arbiter.sv
// Arbitrates two requesters onto one register-file port. Every output is a
// register; read data is returned two cycles after the rf_read strobe because
// the register file answers one cycle after the strobe and the capture into
// rdataN is itself registered.
module reg_arbiter
    import reg_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_MAX = ADDR_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              err0,
    output logic              err1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rf_write,
    output logic              rf_read,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    localparam logic [31:0] ADDR_MAX_U = ADDR_MAX;

    arb_state_e state_q, state_d;

    // Latched command and arbitration state.
    logic              ptr_q, ptr_d;
    logic              idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Read completion in flight: legal read (capture rf_rdata) or
    // out-of-range read (return zero), tagged with its requester.
    logic              rdpend_q, rdpend_d;
    logic              errpend_q, errpend_d;
    logic              pidx_q, pidx_d;

    // Registered outputs.
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              rf_write_q, rf_write_d, rf_read_q, rf_read_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic any_req;
    logic win;
    logic addr_bad;

    rr_arb2 u_rr_arb2 (
        .req0_i (req0),
        .req1_i (req1),
        .ptr_i  (ptr_q),
        .any_o  (any_req),
        .win_o  (win)
    );

    assign addr_bad = ({{(32-ADDR_W){1'b0}}, addr_q} > ADDR_MAX_U);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, command latching, and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdpend_d   = 1'b0;
        errpend_d  = 1'b0;
        pidx_d     = pidx_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        rf_write_d = 1'b0;
        rf_read_d  = 1'b0;
        rf_addr_d  = '0;
        rf_wdata_d = '0;

        // Read completions run beside the FSM so the next command can latch
        // in the same cycle the previous read data is returned.
        if (rdpend_q) begin
            if (pidx_q) begin
                rvalid1_d = 1'b1;
                rdata1_d  = rf_rdata;
            end else begin
                rvalid0_d = 1'b1;
                rdata0_d  = rf_rdata;
            end
        end
        if (errpend_q) begin
            if (pidx_q) begin
                rvalid1_d = 1'b1;
                rdata1_d  = '0;
            end else begin
                rvalid0_d = 1'b1;
                rdata0_d  = '0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    idx_d   = win;
                    we_d    = win ? we1    : we0;
                    addr_d  = win ? addr1  : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                gnt0_d  = ~idx_q;
                gnt1_d  = idx_q;
                ptr_d   = ~idx_q;
                pidx_d  = idx_q;
                state_d = ST_IDLE;
                if (addr_bad) begin
                    err0_d    = ~idx_q;
                    err1_d    = idx_q;
                    errpend_d = ~we_q;
                end else if (we_q) begin
                    rf_write_d = 1'b1;
                    rf_addr_d  = addr_q;
                    rf_wdata_d = wdata_q;
                end else begin
                    rf_read_d = 1'b1;
                    rf_addr_d = addr_q;
                    state_d   = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                rdpend_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command, pointer and output registers; reset abandons any in-flight work.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= 1'b0;
            idx_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdpend_q   <= 1'b0;
            errpend_q  <= 1'b0;
            pidx_q     <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rf_write_q <= 1'b0;
            rf_read_q  <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdpend_q   <= rdpend_d;
            errpend_q  <= errpend_d;
            pidx_q     <= pidx_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rf_write_q <= rf_write_d;
            rf_read_q  <= rf_read_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign err0     = err0_q;
    assign err1     = err1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign rf_write = rf_write_q;
    assign rf_read  = rf_read_q;
    assign rf_addr  = rf_addr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter with a behavioural 100 x 16 register file.
module tb_reg_arbiter;

    localparam int AW = 7;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, err0, err1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          rf_write, rf_read;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata = '0;

    logic [DW-1:0] regs [128];

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt = 0, rd_cnt = 0, rv0_cnt = 0, rv1_cnt = 0;
    int ovl = 0, dgnt = 0, badwr = 0, idlez = 0;

    always #5 clk = ~clk;

    reg_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .err0     (err0),
        .err1     (err1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .rf_write (rf_write),
        .rf_read  (rf_read),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .rf_rdata (rf_rdata)
    );

    // Register-file model plus protocol monitors.
    always @(posedge clk) begin
        if (rf_write) regs[rf_addr] <= rf_wdata;
        rf_rdata <= rf_read ? regs[rf_addr] : '0;
        wr_cnt  <= wr_cnt  + (rf_write ? 1 : 0);
        rd_cnt  <= rd_cnt  + (rf_read  ? 1 : 0);
        rv0_cnt <= rv0_cnt + (rvalid0  ? 1 : 0);
        rv1_cnt <= rv1_cnt + (rvalid1  ? 1 : 0);
        ovl     <= ovl     + ((rf_write && rf_read) ? 1 : 0);
        dgnt    <= dgnt    + ((gnt0 && gnt1) ? 1 : 0);
        badwr   <= badwr   + ((rf_write && rf_addr > 7'd99) ? 1 : 0);
        idlez   <= idlez   + ((!rf_write && !rf_read && (rf_addr != '0 || rf_wdata != '0)) ? 1 : 0);
    end

    typedef struct {
        int            k;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            e_err;
        int            e_vlat;
        logic [DW-1:0] e_rd;
        int            e_wr;
        int            e_rdn;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input bit r, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        if (k == 0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    // One transaction from requester k; cycle counts are relative to raising req.
    task automatic txn(input int k, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int gcyc, output bit err, output int vcyc, output logic [DW-1:0] rd);
        int c;
        c = 0; gcyc = -1; vcyc = -1; err = 1'b0; rd = '0;
        drive(k, 1'b1, we, a, d);
        while (gcyc < 0 && c < 12) begin
            tick(); c++;
            if ((k == 0) ? gnt0 : gnt1) begin
                gcyc = c;
                err  = (k == 0) ? err0 : err1;
                drive(k, 1'b0, we, a, d);
            end
        end
        if (gcyc < 0) drive(k, 1'b0, we, a, d);
        if (!we && gcyc >= 0) begin
            while (vcyc < 0 && c < 16) begin
                tick(); c++;
                if ((k == 0) ? rvalid0 : rvalid1) begin
                    vcyc = c;
                    rd   = (k == 0) ? rdata0 : rdata1;
                end
            end
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int g, vl, w0, r0, rv0;
        bit e;
        logic [DW-1:0] rd;
        w0 = wr_cnt; r0 = rd_cnt; rv0 = (v.k == 0) ? rv0_cnt : rv1_cnt;
        txn(v.k, v.we, v.a, v.d, g, e, vl, rd);
        chk($sformatf("v%0d_gnt_lat", i), g, 2);
        chk($sformatf("v%0d_err", i), e, v.e_err);
        if (!v.we) begin
            chk($sformatf("v%0d_rvalid_lat", i), vl, v.e_vlat);
            chk($sformatf("v%0d_rdata", i), rd, v.e_rd);
        end
        tick(); tick();
        chk($sformatf("v%0d_wr_strobes", i), wr_cnt - w0, v.e_wr);
        chk($sformatf("v%0d_rd_strobes", i), rd_cnt - r0, v.e_rdn);
        chk($sformatf("v%0d_rvalids", i), ((v.k == 0) ? rv0_cnt : rv1_cnt) - rv0, v.we ? 0 : 1);
    endtask

    // Both requesters read at once; checks grant/rvalid timing and data per side.
    task automatic contend(input string nm, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input int e0g, input int e1g, input int e0v, input int e1v,
                           input logic [DW-1:0] ed0, input logic [DW-1:0] ed1);
        int g0, g1, v0, v1;
        logic [DW-1:0] d0, d1;
        g0 = -1; g1 = -1; v0 = -1; v1 = -1; d0 = '0; d1 = '0;
        drive(0, 1'b1, 1'b0, a0, '0);
        drive(1, 1'b1, 1'b0, a1, '0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (gnt0 && g0 < 0) begin g0 = c; drive(0, 1'b0, 1'b0, a0, '0); end
            if (gnt1 && g1 < 0) begin g1 = c; drive(1, 1'b0, 1'b0, a1, '0); end
            if (rvalid0 && v0 < 0) begin v0 = c; d0 = rdata0; end
            if (rvalid1 && v1 < 0) begin v1 = c; d1 = rdata1; end
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        chk({nm, "_gnt0_cyc"}, g0, e0g);
        chk({nm, "_gnt1_cyc"}, g1, e1g);
        chk({nm, "_rvalid0_cyc"}, v0, e0v);
        chk({nm, "_rvalid1_cyc"}, v1, e1v);
        chk({nm, "_rdata0"}, d0, ed0);
        chk({nm, "_rdata1"}, d1, ed1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_pulses"}, {gnt0, gnt1, err0, err1, rvalid0, rvalid1, rf_write, rf_read}, 0);
        chk({nm, "_rf_addr"}, rf_addr, 0);
        chk({nm, "_rf_wdata"}, rf_wdata, 0);
        chk({nm, "_rdata"}, {rdata0, rdata1}, 0);
    endtask

    initial begin
        int g, vl, rv_snap, stray;
        bit e;
        logic [DW-1:0] rd;

        for (int i = 0; i < 128; i++) regs[i] = '0;
        vecs[0] = '{0, 1'b1, 7'd5,   16'hBEEF, 1'b0, 0, 16'h0000, 1, 0};
        vecs[1] = '{0, 1'b0, 7'd5,   16'h0000, 1'b0, 4, 16'hBEEF, 0, 1};
        vecs[2] = '{1, 1'b0, 7'd100, 16'h0000, 1'b1, 3, 16'h0000, 0, 0};
        vecs[3] = '{0, 1'b1, 7'd127, 16'h1234, 1'b1, 0, 16'h0000, 0, 0};
        vecs[4] = '{0, 1'b0, 7'd127, 16'h0000, 1'b1, 3, 16'h0000, 0, 0};
        vecs[5] = '{1, 1'b1, 7'd0,   16'h0001, 1'b0, 0, 16'h0000, 1, 0};
        vecs[6] = '{1, 1'b0, 7'd0,   16'h0000, 1'b0, 4, 16'h0001, 0, 1};
        vecs[7] = '{0, 1'b1, 7'd99,  16'hFFFF, 1'b0, 0, 16'h0000, 1, 0};
        vecs[8] = '{1, 1'b0, 7'd99,  16'h0000, 1'b0, 4, 16'hFFFF, 0, 1};

        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick(); tick(); tick();
        chk_all_zero("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Round-robin: preload, reset so the pointer starts at requester 0.
        txn(0, 1'b1, 7'd10, 16'h0A0A, g, e, vl, rd);
        txn(1, 1'b1, 7'd20, 16'h1414, g, e, vl, rd);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        contend("rr1", 7'd10, 7'd20, 2, 5, 4, 7, 16'h0A0A, 16'h1414);
        contend("rr2", 7'd10, 7'd20, 2, 5, 4, 7, 16'h0A0A, 16'h1414);
        txn(0, 1'b0, 7'd10, '0, g, e, vl, rd);
        chk("rr_single_rdata", rd, 16'h0A0A);
        contend("rr3", 7'd10, 7'd20, 5, 2, 7, 4, 16'h0A0A, 16'h1414);

        // Reset while the read sits in RDWAIT: nothing may come back for it.
        drive(0, 1'b1, 1'b0, 7'd5, '0);
        tick();
        tick();
        chk("rdw_gnt0", gnt0, 1);
        drive(0, 1'b0, 1'b0, 7'd5, '0);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rdw_async");
        rv_snap = rv0_cnt;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (gnt0 || err0 || rvalid0) stray++;
        end
        reset_n = 1'b1;
        txn(0, 1'b1, 7'd99, 16'hA5A5, g, e, vl, rd);
        chk("rdw_first_gnt_lat", g, 2);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (rvalid0) stray++;
        end
        chk("rdw_no_stray", stray, 0);
        chk("rdw_rvalid_cnt", rv0_cnt - rv_snap, 0);
        txn(0, 1'b0, 7'd99, '0, g, e, vl, rd);
        chk("rdw_read_lat", vl, 4);
        chk("rdw_read_data", rd, 16'hA5A5);

        // Full sweep from requester 1: write every address, then read back.
        for (int i = 0; i < 100; i++) begin
            txn(1, 1'b1, 7'(i), 16'(i * 16'd777 + 16'd3), g, e, vl, rd);
            chk($sformatf("swp_w%0d_gnt", i), g, 2);
        end
        for (int i = 0; i < 100; i++) begin
            txn(1, 1'b0, 7'(i), '0, g, e, vl, rd);
            chk($sformatf("swp_r%0d_data", i), rd, 16'(i * 16'd777 + 16'd3));
        end
        tick(); tick();

        chk("never_wr_and_rd", ovl, 0);
        chk("never_two_gnt", dgnt, 0);
        chk("never_wr_out_of_range", badwr, 0);
        chk("rf_bus_zero_when_idle", idlez, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
